// File: rtl/posterior_update_32.sv
// Posterior write-back: buffers Q = L - E_old vectors, then on each E_new pops the oldest Q and
// emits L_new = sat(Q + E_new) two cycles later. Define SAT_SYMMETRIC_EN for a symmetric clamp.
module posterior_update_32 #(
  parameter int unsigned W     = 6,
  parameter int unsigned Wc    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W*Wc-1:0]         q_in,
  input  logic                    q_valid,
  input  logic [W*Wc-1:0]         e_in,
  input  logic                    e_valid,
  output logic [W*Wc-1:0]         l_out,
  output logic                    l_valid,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf_err,
  output logic                    unf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned VW = W * Wc;
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  localparam logic signed [W:0] SatMax = (W+1)'((1 << (W - 1)) - 1);
`ifdef SAT_SYMMETRIC_EN
  // Keeps -2^(W-1) out of the posterior so a later negation cannot overflow.
  localparam logic signed [W:0] SatMin = -SatMax;
`else
  localparam logic signed [W:0] SatMin = (W+1)'(-(1 << (W - 1)));
`endif

  logic [VW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, unf_q;
  logic            push, pop;
  logic            s1_valid_q, l_valid_q;
  logic signed [W:0] sum_d [Wc];
  logic signed [W:0] sum_q [Wc];
  logic [VW-1:0]   head;
  logic [VW-1:0]   sat_d;
  logic [VW-1:0]   l_out_q;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign pop     = e_valid && !empty;
  assign push    = q_valid && (!full || pop);
  assign head    = mem_q[rd_ptr_q];

  assign q_count = count_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
  assign l_out   = l_out_q;
  assign l_valid = l_valid_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sign-extend each element to W+1 bits so the sum cannot wrap before saturation.
  always_comb begin
    for (int k = 0; k < Wc; k++) begin
      sum_d[k] = {head[W*k+W-1], head[W*k +: W]} + {e_in[W*k+W-1], e_in[W*k +: W]};
    end
  end

  always_comb begin
    sat_d = '0;
    for (int k = 0; k < Wc; k++) begin
      if (sum_q[k] > SatMax) begin
        sat_d[W*k +: W] = SatMax[W-1:0];
      end else if (sum_q[k] < SatMin) begin
        sat_d[W*k +: W] = SatMin[W-1:0];
      end else begin
        sat_d[W*k +: W] = sum_q[k][W-1:0];
      end
    end
  end

  // Buffer storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= q_in;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      l_valid_q  <= 1'b0;
      l_out_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      if (q_valid && full && !pop) begin
        ovf_q <= 1'b1;
      end
      if (e_valid && empty) begin
        unf_q <= 1'b1;
      end
      s1_valid_q <= pop;
      l_valid_q  <= s1_valid_q;
      if (s1_valid_q) begin
        l_out_q <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_posterior_update_32.sv
// Directed bench for posterior_update_32: reset, saturation, FIFO order, overflow/underflow
// and reset while a vector is in flight.
module tb_posterior_update_32;

  localparam int unsigned VW = 192;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] q_in, e_in;
  logic          q_valid, e_valid;
  logic [VW-1:0] l_out;
  logic          l_valid;
  logic [3:0]    q_count;
  logic          full, empty, ovf_err, unf_err;

  int errors = 0;
  int checks = 0;

`ifdef SAT_SYMMETRIC_EN
  localparam logic [5:0] NegMin = 6'h21;  // -31
`else
  localparam logic [5:0] NegMin = 6'h20;  // -32
`endif

  posterior_update_32 dut (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .q_valid (q_valid),
    .e_in    (e_in),
    .e_valid (e_valid),
    .l_out   (l_out),
    .l_valid (l_valid),
    .q_count (q_count),
    .full    (full),
    .empty   (empty),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] rep(input logic [5:0] v);
    rep = {32{v}};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q_valid = 1'b0;
    e_valid = 1'b0;
    q_in = '0;
    e_in = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic push_tags(input int n);
    for (int t = 1; t <= n; t++) begin
      q_in = rep(6'(t));
      q_valid = 1'b1;
      step();
    end
    q_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL reset_l_valid got=%b want=0", l_valid); end
    checks++; if (l_out !== '0) begin errors++; $display("FAIL reset_l_out got=%h want=0", l_out); end
    checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL reset_q_count got=%0d want=0", q_count); end
    checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_full_empty got=%b%b want=01", full, empty); end
    checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", ovf_err, unf_err); end
  endtask

  task automatic test_single();
    do_reset();
    q_in = rep(6'd5); q_valid = 1'b1;
    step();
    q_valid = 1'b0;
    checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL single_count1 got=%0d want=1", q_count); end
    step();
    e_in = rep(6'h3d); e_valid = 1'b1;  // -3
    step();
    e_valid = 1'b0;
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b want=0", l_valid); end
    checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL single_count0 got=%0d want=0", q_count); end
    step();
    checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", l_valid); end
    checks++; if (l_out !== rep(6'd2)) begin errors++; $display("FAIL single_data got=%h want=%h", l_out, rep(6'd2)); end
    step();
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b want=0", l_valid); end
    checks++; if (l_out !== rep(6'd2)) begin errors++; $display("FAIL single_hold got=%h want=%h", l_out, rep(6'd2)); end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] qv [4];
    logic [VW-1:0] ev [4];
    logic [VW-1:0] xv [4];
    qv[0] = rep(6'd20);  ev[0] = rep(6'd15);  xv[0] = rep(6'd31);
    qv[1] = rep(6'h2c);  ev[1] = rep(6'h2c);  xv[1] = rep(NegMin);   // -20 + -20
    qv[2] = rep(6'd10);  ev[2] = rep(6'h22);  xv[2] = rep(6'h2c);    // 10 + -30 = -20
    qv[3] = rep(6'd0);   ev[3] = rep(6'd0);   xv[3] = rep(6'd0);
    qv[3][5:0] = 6'd31;  ev[3][5:0] = 6'd1;   xv[3][5:0] = 6'd31;
    qv[3][191:186] = 6'h20;                   xv[3][191:186] = NegMin;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q_in = qv[i]; q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      e_in = ev[i]; e_valid = 1'b1;
      step();
      e_valid = 1'b0;
      step();
      checks++; if (l_valid !== 1'b1 || l_out !== xv[i]) begin
        errors++; $display("FAIL sat_%0d got=%b/%h want=1/%h", i, l_valid, l_out, xv[i]);
      end
    end
  endtask

  task automatic test_fill_order();
    do_reset();
    push_tags(8);
    checks++; if (full !== 1'b1 || q_count !== 4'd8) begin errors++; $display("FAIL fill_full got=%b/%0d want=1/8", full, q_count); end
    q_in = rep(6'd9); q_valid = 1'b1;
    step();
    q_valid = 1'b0;
    checks++; if (ovf_err !== 1'b1 || q_count !== 4'd8) begin errors++; $display("FAIL fill_ovf got=%b/%0d want=1/8", ovf_err, q_count); end
    e_in = '0;
    for (int i = 0; i <= 8; i++) begin
      e_valid = (i < 8);
      step();
      if (i >= 1) begin
        checks++; if (l_valid !== 1'b1 || l_out !== rep(6'(i))) begin
          errors++; $display("FAIL fill_order_%0d got=%b/%h want=1/%h", i, l_valid, l_out, rep(6'(i)));
        end
      end
    end
    e_valid = 1'b0;
    checks++; if (empty !== 1'b1 || ovf_err !== 1'b1) begin errors++; $display("FAIL fill_empty got=%b/%b want=1/1", empty, ovf_err); end
    step();
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL fill_tail got=%b want=0", l_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_tags(8);
    q_in = rep(6'd9); q_valid = 1'b1;
    e_in = '0; e_valid = 1'b1;
    step();
    q_valid = 1'b0;
    checks++; if (ovf_err !== 1'b0 || q_count !== 4'd8) begin errors++; $display("FAIL b2b_full got=%b/%0d want=0/8", ovf_err, q_count); end
    for (int i = 0; i <= 8; i++) begin
      e_valid = (i < 8);
      step();
      checks++; if (l_valid !== 1'b1 || l_out !== rep(6'(i + 1))) begin
        errors++; $display("FAIL b2b_order_%0d got=%b/%h want=1/%h", i, l_valid, l_out, rep(6'(i + 1)));
      end
    end
    e_valid = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b want=1", empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    e_in = rep(6'd1); e_valid = 1'b1;
    step();
    e_valid = 1'b0;
    checks++; if (unf_err !== 1'b1 || q_count !== 4'd0) begin errors++; $display("FAIL unf_flag got=%b/%0d want=1/0", unf_err, q_count); end
    step();
    step();
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL unf_no_valid got=%b want=0", l_valid); end
    do_reset();
    q_in = rep(6'd7); q_valid = 1'b1;
    e_in = rep(6'd1); e_valid = 1'b1;
    step();
    q_valid = 1'b0; e_valid = 1'b0;
    checks++; if (unf_err !== 1'b1 || q_count !== 4'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL unf_push got=%b/%0d/%b want=1/1/0", unf_err, q_count, empty);
    end
    step();
    step();
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL unf_no_bypass got=%b want=0", l_valid); end
    e_in = rep(6'd2); e_valid = 1'b1;
    step();
    e_valid = 1'b0;
    step();
    checks++; if (l_valid !== 1'b1 || l_out !== rep(6'd9)) begin errors++; $display("FAIL unf_data got=%b/%h want=1/%h", l_valid, l_out, rep(6'd9)); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    e_valid = 1'b1;
    step();
    e_valid = 1'b0;
    push_tags(4);
    e_in = '0; e_valid = 1'b1;
    step();
    e_valid = 1'b0;
    checks++; if (q_count !== 4'd3 || unf_err !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0d/%b want=3/1", q_count, unf_err); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL mid_valid0 got=%b want=0", l_valid); end
    checks++; if (q_count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_count got=%0d/%b want=0/1", q_count, empty); end
    checks++; if (unf_err !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL mid_flags got=%b%b want=00", unf_err, ovf_err); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL mid_after_%0d got=%b want=0", i, l_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_fill_order();
    test_back_to_back();
    test_underflow();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
